// File: rtl/mem_sweep_sched_if.sv
// Host / sweep-control / memory-port bundle for mem_sweep_sched.
// Pure wiring, no latency.
// Host stalls through h_ready; the memory port has no backpressure.
interface mem_sweep_sched_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  h_en;
    logic [3:0]            h_we;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [31:0]           h_din;
    logic                  h_ready;
    logic                  h_dvalid;
    logic [31:0]           h_dout;

    logic                  sw_start;
    logic                  sw_abort;
    logic [ADDR_WIDTH-1:0] sw_first;
    logic [ADDR_WIDTH-1:0] sw_last;
    logic [31:0]           sw_set;
    logic [31:0]           sw_clr;
    logic                  sw_busy;
    logic                  sw_done;
    logic [ADDR_WIDTH:0]   sw_count;

    logic                  m_en;
    logic [3:0]            m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [31:0]           m_din;
    logic [31:0]           m_dout;

    // Scheduler side
    modport slave (
        input  h_en, h_we, h_addr, h_din,
        output h_ready, h_dvalid, h_dout,
        input  sw_start, sw_abort, sw_first, sw_last, sw_set, sw_clr,
        output sw_busy, sw_done, sw_count,
        output m_en, m_we, m_addr, m_din,
        input  m_dout
    );

    // Host / controller / memory side
    modport master (
        output h_en, h_we, h_addr, h_din,
        input  h_ready, h_dvalid, h_dout,
        output sw_start, sw_abort, sw_first, sw_last, sw_set, sw_clr,
        input  sw_busy, sw_done, sw_count,
        input  m_en, m_we, m_addr, m_din,
        output m_dout
    );
endinterface

// File: rtl/mem_sweep_sched.sv
// Shares one single-port word RAM between the host path and a read-modify-write sweep engine.
// Grant is combinational (no added latency); host read data returns one cycle after grant.
// Host is held off via h_ready on contention (round-robin) and on a write hazard to the sweep word.
module mem_sweep_sched #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_sweep_sched_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [31:0]           set_q, set_d;
    logic [31:0]           clr_q, clr_d;
    logic [31:0]           word_q, word_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic                  rr_q, rr_d;      // 0: host wins next contention
    logic                  hdv_q, hdv_d;

    logic sw_req, hazard, h_req, gnt_h, gnt_s;

    // Arbitration: round-robin between host and sweep, host writes to the in-flight word held off
    always_comb begin
        sw_req = (state_q == S_RD) || (state_q == S_WR);
        hazard = ((state_q == S_WAIT) || (state_q == S_WR)) &&
                 (bus.h_we != 4'h0) && (bus.h_addr == ptr_q);
        h_req  = bus.h_en && !hazard;
        gnt_h  = h_req && (!sw_req || !rr_q);
        gnt_s  = sw_req && (!h_req || rr_q);
        rr_d   = (h_req && sw_req) ? !rr_q : rr_q;
        hdv_d  = gnt_h && (bus.h_we == 4'h0);
    end

    // Memory port mux and status outputs
    always_comb begin
        bus.m_en     = gnt_h || gnt_s;
        bus.m_we     = 4'h0;
        bus.m_addr   = '0;
        bus.m_din    = 32'h0;
        if (gnt_h) begin
            bus.m_we   = bus.h_we;
            bus.m_addr = bus.h_addr;
            bus.m_din  = bus.h_din;
        end else if (gnt_s) begin
            bus.m_we   = (state_q == S_WR) ? 4'hF : 4'h0;
            bus.m_addr = ptr_q;
            bus.m_din  = word_q;
        end
        bus.h_ready  = gnt_h;
        bus.h_dvalid = hdv_q;
        bus.h_dout   = bus.m_dout;
        bus.sw_busy  = (state_q != S_IDLE);
        bus.sw_done  = (state_q == S_DONE);
        bus.sw_count = cnt_q;
    end

    // Sweep engine next state: read word, merge set/clear, write back, advance
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        set_d   = set_q;
        clr_d   = clr_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        abort_d = abort_q || bus.sw_abort;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (bus.sw_start) begin
                    ptr_d   = bus.sw_first;
                    last_d  = bus.sw_last;
                    set_d   = bus.sw_set;
                    clr_d   = bus.sw_clr;
                    cnt_d   = '0;
                    abort_d = bus.sw_abort;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (gnt_s) state_d = S_WAIT;
            end
            S_WAIT: begin
                word_d  = (bus.m_dout & ~clr_q) | set_q;
                state_d = S_WR;
            end
            S_WR: begin
                if (gnt_s) begin
                    cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    if ((ptr_q == last_q) || abort_q) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        state_d = S_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            last_q  <= '0;
            set_q   <= 32'h0;
            clr_q   <= 32'h0;
            word_q  <= 32'h0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            rr_q    <= 1'b0;
            hdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            set_q   <= set_d;
            clr_q   <= clr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            rr_q    <= rr_d;
            hdv_q   <= hdv_d;
        end
    end
endmodule

// File: tb/tb_mem_sweep_sched.sv
// Bench for mem_sweep_sched: behavioural RAM, host read scoreboard, sweep scenarios.
module tb_mem_sweep_sched;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_sweep_sched_if #(.ADDR_WIDTH(AW)) bus();
    mem_sweep_sched #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [0:255];
    logic        bd_en;
    logic [7:0]  bd_addr;
    logic [31:0] bd_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    logic [31:0] exp_q [$];

    // Single-port RAM with a backdoor loader; read data registered one cycle
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_dat;
        else if (bus.m_en) begin
            if (bus.m_we == 4'h0) bus.m_dout <= mem[bus.m_addr];
            else for (int b = 0; b < 4; b++)
                if (bus.m_we[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_din[8*b +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host read returns and sweep-done pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sw_done) done_cnt++;
            if (bus.h_dvalid) begin
                if (exp_q.size() == 0) chk("dvalid_unexpected", 1, 0);
                else chk("host_rdata", bus.h_dout, exp_q.pop_front());
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        bd_en = 1'b1; bd_addr = a; bd_dat = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    // Entered and left at a negedge; holds the request until granted
    task automatic host_op(input logic [3:0] we, input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] exp, input int budget, output int waited);
        bus.h_en = 1'b1; bus.h_we = we; bus.h_addr = a; bus.h_din = d;
        waited = 0;
        #1;
        while (!bus.h_ready && waited < budget) begin
            @(negedge clk); #1; waited++;
        end
        if (!bus.h_ready) chk("host_grant_timeout", 0, 1);
        else if (we == 4'h0) exp_q.push_back(exp);
        @(negedge clk);
        bus.h_en = 1'b0; bus.h_we = 4'h0;
    endtask

    task automatic start_sweep(input logic [7:0] f, input logic [7:0] l, input logic [31:0] s,
                               input logic [31:0] c, input logic ab, output int st);
        bus.sw_start = 1'b1; bus.sw_abort = ab;
        bus.sw_first = f; bus.sw_last = l; bus.sw_set = s; bus.sw_clr = c;
        st = cyc;
        @(negedge clk);
        bus.sw_start = 1'b0; bus.sw_abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget && dc < 0; i++) begin
            @(negedge clk);
            if (bus.sw_done) dc = cyc;
        end
        if (dc < 0) chk("sweep_done_timeout", 0, 1);
    endtask

    int st, dc, w, mx, st3, dc3, w3, d0;

    initial begin
        reset = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_dat = '0;
        bus.h_en = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_din = 0;
        bus.sw_start = 0; bus.sw_abort = 0; bus.sw_first = 0; bus.sw_last = 0;
        bus.sw_set = 0; bus.sw_clr = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_dvalid", bus.h_dvalid, 0);
        chk("rst_busy", bus.sw_busy, 0);
        chk("rst_done", bus.sw_done, 0);
        chk("rst_count", bus.sw_count, 0);
        chk("rst_m_en", bus.m_en, 0);
        chk("rst_m_we", bus.m_we, 0);
        @(negedge clk);

        // 1: host-only read
        poke(8'h05, 32'hDEADBEEF);
        host_op(4'h0, 8'h05, 0, 32'hDEADBEEF, 4, w);
        chk("t1_ready_same_cycle", w, 0);
        @(negedge clk);
        chk("t1_queue_drained", exp_q.size(), 0);

        // 2: plain sweep 0x10..0x13
        for (int i = 0; i < 4; i++) poke(8'h10 + i[7:0], 32'h12345678);
        start_sweep(8'h10, 8'h13, 32'h000000FF, 32'hFFFF0000, 1'b0, st);
        chk("t2_busy", bus.sw_busy, 1);
        wait_done(40, dc);
        chk("t2_done_latency", dc - st, 13);
        chk("t2_count", bus.sw_count, 4);
        for (int i = 0; i < 4; i++) chk("t2_word", mem[8'h10 + i[7:0]], 32'h000056FF);
        @(negedge clk);
        chk("t2_done_one_cycle", bus.sw_done, 0);
        chk("t2_idle", bus.sw_busy, 0);

        // 3: sweep under back-to-back host reads
        for (int i = 0; i < 4; i++) poke(8'h10 + i[7:0], 32'h12345678);
        for (int i = 0; i < 8; i++) poke(8'h40 + i[7:0], 32'h10000000 + i);
        mx = 0;
        fork
            begin
                start_sweep(8'h10, 8'h13, 32'h000000FF, 32'hFFFF0000, 1'b0, st3);
                wait_done(40, dc3);
                chk("t3_within_20", (dc3 - st3) <= 20, 1);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    host_op(4'h0, 8'h40 + i[7:0], 0, 32'h10000000 + i, 6, w3);
                    if (w3 > mx) mx = w3;
                end
            end
        join
        chk("t3_host_wait_max", mx, 1);
        for (int i = 0; i < 4; i++) chk("t3_word", mem[8'h10 + i[7:0]], 32'h000056FF);
        repeat (2) @(negedge clk);
        chk("t3_queue_drained", exp_q.size(), 0);

        // 4: host write hazard on the word in flight
        for (int i = 0; i < 4; i++) poke(8'h10 + i[7:0], 32'h12345678);
        start_sweep(8'h10, 8'h13, 32'h000000FF, 32'hFFFF0000, 1'b0, st);
        repeat (4) @(negedge clk);
        host_op(4'hF, 8'h11, 32'hCAFEF00D, 0, 10, w);
        chk("t4_stalled_past_wr", (w >= 2) && (w <= 3), 1);
        wait_done(40, dc);
        chk("t4_mem11", mem[8'h11], 32'hCAFEF00D);
        chk("t4_mem12", mem[8'h12], 32'h000056FF);
        @(negedge clk);

        // 5: wrap through top of memory, start while busy ignored
        poke(8'hFD, 32'h11111111); poke(8'h02, 32'h22222222); poke(8'h80, 32'h33333333);
        for (int i = 0; i < 4; i++) poke(8'hFE + i[7:0], 32'hA5A5A5A5);
        start_sweep(8'hFE, 8'h01, 32'h0000000F, 32'hF0000000, 1'b0, st);
        repeat (2) @(negedge clk);
        start_sweep(8'h80, 8'h80, 32'hFFFFFFFF, 32'h0, 1'b0, st3);
        wait_done(40, dc);
        chk("t5_count", bus.sw_count, 4);
        for (int i = 0; i < 4; i++) chk("t5_word", mem[8'hFE + i[7:0]], 32'h05A5A5AF);
        chk("t5_below", mem[8'hFD], 32'h11111111);
        chk("t5_above", mem[8'h02], 32'h22222222);
        repeat (4) @(negedge clk);
        chk("t5_ignored_start_busy", bus.sw_busy, 0);
        chk("t5_ignored_start_mem", mem[8'h80], 32'h33333333);

        // single-word sweep
        poke(8'h30, 32'h0F0F0F0F); poke(8'h31, 32'h44444444);
        start_sweep(8'h30, 8'h30, 32'h80000000, 32'h0000000F, 1'b0, st);
        wait_done(20, dc);
        chk("t5_one_count", bus.sw_count, 1);
        chk("t5_one_word", mem[8'h30], 32'h8F0F0F00);
        chk("t5_one_next", mem[8'h31], 32'h44444444);
        @(negedge clk);

        // 6: abort during WAIT of 0x11
        for (int i = 0; i < 16; i++) poke(8'h10 + i[7:0], 32'h12345678);
        start_sweep(8'h10, 8'h1F, 32'h000000FF, 32'hFFFF0000, 1'b0, st);
        repeat (4) @(negedge clk);
        bus.sw_abort = 1'b1;
        @(negedge clk);
        bus.sw_abort = 1'b0;
        wait_done(20, dc);
        chk("t6_abort_count", bus.sw_count, 2);
        chk("t6_abort_mem11", mem[8'h11], 32'h000056FF);
        chk("t6_abort_mem12", mem[8'h12], 32'h12345678);
        @(negedge clk);

        // start and abort together: one word only
        poke(8'h20, 32'h12345678); poke(8'h21, 32'h12345678);
        start_sweep(8'h20, 8'h23, 32'h000000FF, 32'hFFFF0000, 1'b1, st);
        wait_done(20, dc);
        chk("t6_startabort_count", bus.sw_count, 1);
        chk("t6_startabort_mem21", mem[8'h21], 32'h12345678);
        @(negedge clk);

        // reset mid-sweep with a host read return pending
        d0 = done_cnt;
        start_sweep(8'h10, 8'h1F, 32'h0, 32'h0, 1'b0, st);
        bus.h_en = 1'b1; bus.h_we = 4'h0; bus.h_addr = 8'h40;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.h_en = 1'b0;
        #1;
        chk("t6_rst_busy_now", bus.sw_busy, 0);
        chk("t6_rst_dvalid_dropped", bus.h_dvalid, 0);
        @(negedge clk);
        chk("t6_rst_busy_edge", bus.sw_busy, 0);
        chk("t6_rst_count", bus.sw_count, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_rst_no_done", done_cnt, d0);
        chk("t6_rst_idle", bus.sw_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
